instruction_fetch_unit: RTL

- Owns the program counter and instruction register.
- Fetches one 32-bit instruction per instruction cycle from instruction memory over a req/ack handshake and presents it, held stable, to the control unit.
- Computes the next PC from the control unit's PC-select field and K constant, or from a register value for BR.
- Sits directly upstream of the control unit: its `instruction` output drives the control unit's `instruction` input.

---
 rtl/instruction_fetch_unit.sv | 107 ++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC and instruction register, fetches one word
// per instruction over a req/ack handshake and holds it for the control unit.
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC      = 64'h0,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pc_load,
  input  logic [1:0]  pc_sel,
  input  logic [63:0] K,
  input  logic [63:0] reg_target,
  input  logic [31:0] imem_data,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [63:0] pc,
  output logic [63:0] pc_plus4,
  output logic        fetch_error,
  output logic [1:0]  fsm_state
);

  // Handshake: imem_req is held high for the whole FETCH state; a word is
  // accepted on any rising edge in FETCH where imem_ack is high, and imem_req
  // drops on that same edge. imem_ack outside FETCH is ignored.
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HOLD = 2'd2, ERROR = 2'd3} state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(FETCH_TIMEOUT - 1);

  state_t      state;
  logic [15:0] timeout_cnt;
  logic [63:0] next_pc;

  assign pc_plus4  = pc + 64'd4;
  assign imem_addr = pc;
  assign fsm_state = state;

  // K is two's complement, so a plain modulo-2^64 add covers negative offsets.
  always_comb begin
    next_pc = pc_plus4;
    case (pc_sel)
      2'b00:   next_pc = pc_plus4;
      2'b01:   next_pc = pc + K;
      2'b10:   next_pc = reg_target;
      default: next_pc = pc;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instruction <= 32'h0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      fetch_error <= 1'b0;
      timeout_cnt <= 16'h0;
    end else begin
      case (state)
        IDLE: begin
          state       <= FETCH;
          imem_req    <= 1'b1;
          timeout_cnt <= 16'h0;
        end
        FETCH: begin
          if (imem_ack) begin
            instruction <= imem_data;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            timeout_cnt <= 16'h0;
            state       <= HOLD;
          end else if (timeout_cnt == TIMEOUT_LAST) begin
            imem_req    <= 1'b0;
            fetch_error <= 1'b1;
            timeout_cnt <= 16'h0;
            state       <= ERROR;
          end else begin
            timeout_cnt <= timeout_cnt + 16'd1;
          end
        end
        HOLD: begin
          if (pc_load) begin
            instr_valid <= 1'b0;
            if (next_pc[1:0] != 2'b00) begin
              // Misaligned target: keep pc pointing at the offending instruction.
              fetch_error <= 1'b1;
              state       <= ERROR;
            end else begin
              pc          <= next_pc;
              imem_req    <= 1'b1;
              timeout_cnt <= 16'h0;
              state       <= FETCH;
            end
          end
        end
        ERROR: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
